instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Sequences instruction fetch for the RISC-V core and owns the program counter.
- Drives the byte address of the combinational instruction memory and captures each returned word with its PC.
- Buffers fetched words in a DEPTH-entry queue and presents them to decode with a valid/ready handshake.
- Handles redirects from branches and jumps, and stops fetching when the PC leaves the populated memory range.

Parameters:
- RESET_PC, 64'h0: PC loaded at reset.
- DEPTH, 2: fetch-queue entries; power of two, at least 2.
- IMEM_BYTES, 84: populated instruction-memory size in bytes. An address is in range iff pc + 4 <= IMEM_BYTES.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle pulse; moves the unit IDLE -> FETCH.
- Instr_Addr, output, 64: byte address to instruction memory; equals the pc register, combinationally.
- Instruction, input, 32: word returned by memory in the same cycle.
- redirect_valid, input, 1: load a new PC and flush the queue.
- redirect_pc, input, 64: redirect target.
- if_valid, output, 1: queue head valid toward decode.
- if_ready, input, 1: decode accepts the head.
- if_pc, output, 64: PC of the queue head.
- if_instr, output, 32: instruction of the queue head.
- fetch_state, output, 2: 0 = IDLE, 1 = FETCH, 2 = HALT.
- out_of_range, output, 1: sticky flag; the PC left [0, IMEM_BYTES).

Behaviour:
- Reset (asynchronous, reset = 0) values:
  - pc = RESET_PC, state = IDLE, queue count = 0.
  - if_valid = 0, if_pc = 0, if_instr = 0, out_of_range = 0.
  - Reset applies immediately, without waiting for a clock edge.
- Fetch condition: a word is fetched in a cycle iff all of the following hold:
  - state = FETCH;
  - redirect_valid = 0;
  - pc is in range;
  - count < DEPTH, or a pop occurs in the same cycle.
- Fetch action: push {pc, Instruction} into the queue; pc <= pc + 4, 64-bit wrap.
- Pop: occurs when if_valid & if_ready.
  - Simultaneous push and pop leaves count unchanged.
  - Order is strictly FIFO; no loss, no duplication.
- if_valid: equals (count != 0) & ~redirect_valid. A handshake in a redirect cycle is nullified.
- Redirect (highest priority, any state):
  - Queue flushed: count <= 0.
  - pc <= {redirect_pc[63:2], 2'b00}; misaligned low bits are dropped.
  - out_of_range <= 0.
  - FETCH and HALT go to FETCH. IDLE stays IDLE with the new pc.
  - Any fetch in that cycle is suppressed.
- State transitions:
  - IDLE -> FETCH on start. start has no effect in FETCH or HALT.
  - FETCH -> HALT when pc is out of range and there is no redirect; out_of_range <= 1.
  - HALT: no fetches; the queue continues to drain normally.
  - HALT -> FETCH only via redirect. If the new pc is also out of range, the unit re-enters HALT on the next cycle.
- Latency and throughput:
  - A word fetched in cycle N is visible at the queue head in cycle N+1.
  - First if_valid occurs 2 cycles after the start pulse (IDLE -> FETCH, then fetch, then visible).
  - Sustained throughput is 1 instruction per cycle when if_ready = 1.
- Backpressure: with the queue full and no pop, pc and Instr_Addr hold.
- Queue pointers wrap modulo DEPTH. count ranges 0..DEPTH and never overflows or underflows.

Test Plan:
1. Load the bubble-sort program, release reset, pulse start, hold if_ready = 1.
   - Required: if_pc = 0x0, 0x4, 0x8 on consecutive cycles.
   - Required: if_instr = 0x00500593, 0x04058863, 0x00000613.
2. After start, hold if_ready = 0 for 5 cycles.
   - Required: queue holds pc 0x0 and 0x4; Instr_Addr stays at 0x8.
   - Then raise if_ready. Required: 0x0, 0x4, 0x8 delivered in order, no duplicates.
3. With the queue full, redirect to 0x4C.
   - Required: if_valid = 0 in the redirect cycle and in the next cycle.
   - Required: the following cycle shows if_pc = 0x4C, if_instr = 0x00160613; the next shows if_pc = 0x50, if_instr = 0xfa000ee3.
4. Run sequentially with if_ready = 1 and IMEM_BYTES = 84.
   - Required: the last entry delivered is 0x50; then fetch_state = 2 and out_of_range = 1.
   - Then redirect to 0x0. Required: out_of_range = 0, fetch_state = 1, if_pc = 0x0 two cycles later.
5. Redirect to 0x4E.
   - Required: fetch from 0x4C; if_pc = 0x4C.
6. Assert reset between clock edges with the queue full.
   - Required: if_valid = 0, fetch_state = 0, Instr_Addr = RESET_PC immediately.
   - After release: no fetch occurs until start.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Groups the instruction-fetch unit's bus signals: the start control, the
// combinational instruction-memory port, the redirect port, the decode-side
// valid/ready handshake and the status outputs.
//
//   master : the fetch unit (drives Instr_Addr, if_*, fetch_state,
//            out_of_range)
//   slave  : the surrounding core / memory (drives start, Instruction,
//            redirect_*, if_ready)
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if;
    logic        start;
    logic [63:0] Instr_Addr;
    logic [31:0] Instruction;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic [1:0]  fetch_state;
    logic        out_of_range;

    modport master (
        input  start, Instruction, redirect_valid, redirect_pc, if_ready,
        output Instr_Addr, if_valid, if_pc, if_instr, fetch_state, out_of_range
    );

    modport slave (
        output start, Instruction, redirect_valid, redirect_pc, if_ready,
        input  Instr_Addr, if_valid, if_pc, if_instr, fetch_state, out_of_range
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Owns the program counter, reads one word per cycle from a combinational
// instruction memory, buffers {pc, word} pairs in a DEPTH-entry FIFO and hands
// them to decode over a valid/ready handshake. Redirects flush the FIFO and
// reload the PC; fetching stops (HALT) once the PC leaves the populated
// memory range.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : instr_fetch_unit_if.master
//             start          one-cycle pulse, IDLE -> FETCH
//             Instr_Addr     byte address to memory (= pc)
//             Instruction    word returned in the same cycle
//             redirect_*     new PC target, flushes the queue
//             if_valid/ready decode handshake; if_pc/if_instr = queue head
//             fetch_state    0 IDLE, 1 FETCH, 2 HALT
//             out_of_range   sticky, cleared by redirect
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          DEPTH      = 2,
    parameter int          IMEM_BYTES = 84
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master bus
);

    localparam int             PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_CNT  = (PTR_W + 1)'(DEPTH);
    localparam logic [64:0]    IMEM_LIMIT = 65'(IMEM_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t           state;
    logic [63:0]      pc;
    logic             oor;

    logic [63:0]      q_pc    [DEPTH];
    logic [31:0]      q_instr [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;

    logic in_range;
    logic not_empty;
    logic pop;
    logic push;

    // 65-bit sum so a PC near 2^64 cannot wrap back into range.
    assign in_range  = ({1'b0, pc} + 65'd4) <= IMEM_LIMIT;
    assign not_empty = (count != '0);

    // A redirect hides the head so no stale instruction escapes the flush.
    assign bus.if_valid = not_empty & ~bus.redirect_valid;
    assign pop          = bus.if_valid & bus.if_ready;

    // A full queue can still accept a word when the head leaves this cycle.
    assign push = (state == ST_FETCH) && !bus.redirect_valid && in_range &&
                  ((count < DEPTH_CNT) || pop);

    assign bus.Instr_Addr   = pc;
    assign bus.fetch_state  = state;
    assign bus.out_of_range = oor;
    // Gating keeps the head outputs at zero after reset without having to
    // reset the storage array.
    assign bus.if_pc    = not_empty ? q_pc[rd_ptr]    : 64'h0;
    assign bus.if_instr = not_empty ? q_instr[rd_ptr] : 32'h0;

    // NOTE: queue storage has no reset; count alone decides which entries are
    // meaningful, so the array maps onto plain flops/RAM without reset muxes.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= pc;
            q_instr[wr_ptr] <= bus.Instruction;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            pc     <= RESET_PC;
            oor    <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.redirect_valid) begin
            // Redirect beats everything else, including start and fetch.
            pc     <= {bus.redirect_pc[63:2], 2'b00};
            oor    <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            if (state != ST_IDLE) begin
                state <= ST_FETCH;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (!in_range) begin
                        state <= ST_HALT;
                        oor   <= 1'b1;
                    end
                end
                default: begin
                    // HALT: leave only through a redirect; queue keeps draining.
                end
            endcase

            if (push) begin
                pc     <= pc + 64'd4;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule
